vector_alu_pipe: RTL

- Parametrised, pipelined successor to the scalar N-bit ALU.
- Operates on LANES independent N-bit lanes per transaction, with 8 operations, per-lane flags, a lane mask and a sideband tag.
- Two-stage valid/ready pipeline with full throughput under backpressure.
- Sits in the vector execute stage, between the operand-read stage and writeback.

---
 rtl/vector_alu_pipe_if.sv | 38 +++
 rtl/vector_alu_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vector_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_alu_pipe_if
// Purpose  : Handshake and data bundle for vector_alu_pipe. The upstream
//            side (operand read) and downstream side (writeback) share
//            one interface. The master drives the operands and out_ready.
//            The slave, which is the ALU, drives in_ready and the results.
// Revision : 1.0 - initial release
// ============================================================================
interface vector_alu_pipe_if #(
   parameter int N     = 32,
   parameter int LANES = 4,
   parameter int TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [LANES*N-1:0]   Op_A;
   logic [LANES*N-1:0]   Op_B;
   logic [2:0]           Control;
   logic [LANES-1:0]     lane_en;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [LANES*N-1:0]   Result;
   logic [LANES*4-1:0]   Flags;
   logic [TAG_W-1:0]     out_tag;

   modport master (
      output in_valid, Op_A, Op_B, Control, lane_en, in_tag, out_ready,
      input  in_ready, out_valid, Result, Flags, out_tag
   );

   modport slave (
      input  in_valid, Op_A, Op_B, Control, lane_en, in_tag, out_ready,
      output in_ready, out_valid, Result, Flags, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/vector_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vector_alu_pipe
// Purpose  : Two-stage valid/ready vector ALU with LANES independent N-bit
//            lanes. It supports add, sub, and, or, xor, sll, srl and sra.
//            Each lane has its own flags {neg, zero, carry, ovf}. Lanes
//            with lane_en clear pass Op_A through unchanged.
//            The sideband tag is carried alongside each transaction.
//            Optional macro VALU_SATURATE_EN makes add/sub saturate on
//            signed overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module vector_alu_pipe #(
   parameter int N     = 32,
   parameter int LANES = 4,
   parameter int TAG_W = 4
) (
   input  wire logic           clk,
   input  wire logic           rst,
   vector_alu_pipe_if.slave    bus
);

   localparam int         c_SH_W   = $clog2(N);
   localparam logic [2:0] c_OP_ADD = 3'b000;
   localparam logic [2:0] c_OP_SUB = 3'b001;
   localparam logic [2:0] c_OP_AND = 3'b010;
   localparam logic [2:0] c_OP_OR  = 3'b011;
   localparam logic [2:0] c_OP_XOR = 3'b100;
   localparam logic [2:0] c_OP_SLL = 3'b101;
   localparam logic [2:0] c_OP_SRL = 3'b110;

   // Stage 1: captured operands
   logic                 r_s1_valid;
   logic [LANES*N-1:0]   r_s1_a;
   logic [LANES*N-1:0]   r_s1_b;
   logic [2:0]           r_s1_ctrl;
   logic [LANES-1:0]     r_s1_en;
   logic [TAG_W-1:0]     r_s1_tag;

   // Stage 2: registered results
   logic                 r_s2_valid;
   logic [LANES*N-1:0]   r_s2_result;
   logic [LANES*4-1:0]   r_s2_flags;
   logic [TAG_W-1:0]     r_s2_tag;

   logic                 w_s2_adv;
   logic                 w_in_ready;
   logic [LANES*N-1:0]   w_lane_result;
   logic [LANES*4-1:0]   w_lane_flags;

   // A stage may move forward when the stage after it is empty or draining.
   // in_ready depends on state and out_ready only, never on in_valid.
   assign w_s2_adv   = !r_s2_valid || bus.out_ready;
   assign w_in_ready = !r_s1_valid || w_s2_adv;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.Result    = r_s2_result;
   assign bus.Flags     = r_s2_flags;
   assign bus.out_tag   = r_s2_tag;

   // Stage 1 register: load on accept, otherwise empty out as stage 2 takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_ctrl  <= '0;
         r_s1_en    <= '0;
         r_s1_tag   <= '0;
      end else if (w_in_ready) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_a    <= bus.Op_A;
            r_s1_b    <= bus.Op_B;
            r_s1_ctrl <= bus.Control;
            r_s1_en   <= bus.lane_en;
            r_s1_tag  <= bus.in_tag;
         end
      end
   end

   // Per-lane combinational datapath fed from stage 1
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [N-1:0]      w_a;
         logic [N-1:0]      w_b;
         logic [N-1:0]      w_b_eff;
         logic [N:0]        w_sum;
         logic [N:0]        w_shl;
         logic [N:0]        w_shr;
         logic [N:0]        w_sra;
         logic [c_SH_W-1:0] w_sh;
         logic              w_sub;
         logic              w_add_ovf;
         logic [N-1:0]      w_res;
         logic              w_carry;
         logic              w_ovf;

         assign w_a       = r_s1_a[gi*N +: N];
         assign w_b       = r_s1_b[gi*N +: N];
         assign w_sub     = (r_s1_ctrl == c_OP_SUB);
         // Subtract is A + ~B + 1, so carry-out of 1 means no borrow.
         assign w_b_eff   = w_sub ? ~w_b : w_b;
         assign w_sum     = {1'b0, w_a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_sub};
         assign w_add_ovf = (w_a[N-1] == w_b_eff[N-1]) && (w_sum[N-1] != w_a[N-1]);
         // The extra guard bit of each shift catches the last bit shifted out.
         // That bit reads as 0 when the shift amount is zero.
         assign w_sh      = w_b[c_SH_W-1:0];
         assign w_shl     = {1'b0, w_a} << w_sh;
         assign w_shr     = {w_a, 1'b0} >> w_sh;
         assign w_sra     = $signed({w_a, 1'b0}) >>> w_sh;

         // Operation select and carry/overflow generation for this lane
         always_comb begin
            w_res   = w_sum[N-1:0];
            w_carry = 1'b0;
            w_ovf   = 1'b0;
            case (r_s1_ctrl)
               c_OP_ADD, c_OP_SUB: begin
                  w_res   = w_sum[N-1:0];
                  w_carry = w_sum[N];
                  w_ovf   = w_add_ovf;
`ifdef VALU_SATURATE_EN
                  // Overflow sign follows operand A: positive A clips high.
                  if (w_add_ovf) begin
                     w_res = w_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                  end
`endif
               end
               c_OP_AND: w_res = w_a & w_b;
               c_OP_OR:  w_res = w_a | w_b;
               c_OP_XOR: w_res = w_a ^ w_b;
               c_OP_SLL: begin
                  w_res   = w_shl[N-1:0];
                  w_carry = w_shl[N];
               end
               c_OP_SRL: begin
                  w_res   = w_shr[N:1];
                  w_carry = w_shr[0];
               end
               default: begin
                  w_res   = w_sra[N:1];
                  w_carry = w_sra[0];
               end
            endcase
         end

         assign w_lane_result[gi*N +: N] = r_s1_en[gi] ? w_res : w_a;
         assign w_lane_flags[gi*4 +: 4]  = r_s1_en[gi] ?
                                           {w_res[N-1], (w_res == '0), w_carry, w_ovf} : 4'b0000;
      end
   endgenerate

   // Stage 2 register: holds while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_result <= '0;
         r_s2_flags  <= '0;
         r_s2_tag    <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_result <= w_lane_result;
            r_s2_flags  <= w_lane_flags;
            r_s2_tag    <= r_s1_tag;
         end
      end
   end

endmodule
`default_nettype wire
